adc_buffer_reader: RTL and testbench

Streams a block of stored ADC samples out of the 4096 × 8-bit sample buffer onto a valid/ready byte stream for the host link. It drives the buffer's read port (12-bit address, synchronous read, 1-cycle latency, no read enable) and sits between the buffer and the downstream serialiser. It hides the RAM latency behind a 2-entry output FIFO so that it sustains one sample per clock under continuous `m_ready`.

---
 rtl/adc_buffer_reader.sv | 141 ++++++++++++++
 tb/tb_adc_buffer_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_buffer_reader.sv
// Streams a block of samples from a synchronous-read sample buffer onto a valid/ready byte stream.
// A 2-entry output FIFO hides the 1-cycle RAM latency so continuous m_ready gives one sample per clock.
module adc_buffer_reader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e              state_q;
    logic [LEN_W-1:0]    issue_left_q;
    logic [LEN_W-1:0]    send_left_q, send_left_d;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic                head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic                busy_q, done_q, last_q;
    logic                pop_c, issue_c;
    logic [1:0]          occ_c;
    logic [LEN_W-1:0]    len_clamp_c;

    // Issue decision and FIFO next-state; occupancy counts reads still in flight.
    always_comb begin
        pop_c       = head_vld_q & m_ready;
        occ_c       = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(inflight_q) - 2'(pop_c);
        issue_c     = (state_q == RUN) && (issue_left_q != '0) && (occ_c < 2'd2);
        len_clamp_c = (length > DEPTH) ? DEPTH : length;
        head_d      = head_q;
        head_vld_d  = head_vld_q;
        tail_d      = tail_q;
        tail_vld_d  = tail_vld_q;
        if (pop_c) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                tail_vld_d = inflight_q;
                if (inflight_q) tail_d = rd_data;
            end else begin
                head_vld_d = inflight_q;
                if (inflight_q) head_d = rd_data;
            end
        end else if (inflight_q) begin
            if (head_vld_q) begin
                tail_d     = rd_data;
                tail_vld_d = 1'b1;
            end else begin
                head_d     = rd_data;
                head_vld_d = 1'b1;
            end
        end
        send_left_d = pop_c ? send_left_q - LEN_W'(1) : send_left_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_left_q <= '0;
            send_left_q  <= '0;
            rd_addr_q    <= '0;
            inflight_q   <= 1'b0;
            head_q       <= '0;
            head_vld_q   <= 1'b0;
            tail_q       <= '0;
            tail_vld_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            last_q       <= 1'b0;
        end else if (abort) begin
            state_q      <= IDLE;
            issue_left_q <= '0;
            send_left_q  <= '0;
            inflight_q   <= 1'b0;
            head_vld_q   <= 1'b0;
            tail_vld_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            inflight_q  <= issue_c;
            head_q      <= head_d;
            head_vld_q  <= head_vld_d;
            tail_q      <= tail_d;
            tail_vld_q  <= tail_vld_d;
            send_left_q <= send_left_d;
            last_q      <= head_vld_d && (send_left_d == LEN_W'(1));
            if (issue_c) begin
                rd_addr_q    <= rd_addr_q + ADDR_W'(1);
                issue_left_q <= issue_left_q - LEN_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start && (length != '0)) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        rd_addr_q    <= base_addr;
                        issue_left_q <= len_clamp_c;
                        send_left_q  <= len_clamp_c;
                    end
                end
                RUN: begin
                    if (issue_c && (issue_left_q == LEN_W'(1))) state_q <= DRAIN;
                end
                DRAIN: begin
                    // All reads are issued, so the final sample always leaves from here.
                    if (pop_c && (send_left_q == LEN_W'(1))) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_addr = rd_addr_q;
    assign m_data  = head_q;
    assign m_valid = head_vld_q;
    assign m_last  = last_q;

endmodule

// File: tb/tb_adc_buffer_reader.sv
// Bench for adc_buffer_reader: behavioural buffer model plus per-scenario tasks with a queue-based
// reference of the expected byte stream; inputs driven and outputs sampled on the falling edge.
module tb_adc_buffer_reader;

    logic        clk = 1'b0;
    logic        rst, start, abort, m_ready;
    logic [11:0] base_addr, rd_addr;
    logic [12:0] length;
    logic [7:0]  rd_data, m_data;
    logic        busy, done, m_valid, m_last;
    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Synchronous-read sample buffer, 1-cycle latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    adc_buffer_reader #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    task automatic preload();
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
            m_data !== 8'h00 || rd_addr !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b valid=%b last=%b data=%h addr=%h expected all 0",
                     busy, done, m_valid, m_last, m_data, rd_addr);
        end
        rst = 1'b0;
    endtask

    // Fixed-timing stream: start in cycle 0, check every output in cycles 1..last_c+2
    task automatic test_timed(input string name, input int base, input int len, input int ign_at);
        int       n;
        logic     ev, el, ed, eb;
        logic [7:0] edat;
        n = (len > 4096) ? 4096 : len;
        @(negedge clk);
        start = 1'b1; base_addr = 12'(base); length = 13'(len); m_ready = 1'b1;
        for (int c = 1; c <= n + 4; c++) begin
            @(negedge clk);
            start = (c == ign_at);
            if (c == ign_at) begin base_addr = 12'd0; length = 13'd3; end
            ev   = (c >= 3) && (c <= n + 2);
            el   = (c == n + 2);
            ed   = (c == n + 3);
            eb   = (c >= 1) && (c <= n + 2);
            edat = mem[(base + c - 3) % 4096];
            checks++;
            if (m_valid !== ev || m_last !== el || done !== ed || busy !== eb ||
                (ev && m_data !== edat)) begin
                errors++;
                $display("FAIL %s c=%0d: got v=%b l=%b d=%b b=%b data=%h expected v=%b l=%b d=%b b=%b data=%h",
                         name, c, m_valid, m_last, done, busy, m_data, ev, el, ed, eb, edat);
            end
            if (c <= n) begin
                checks++;
                if (rd_addr !== 12'((base + c - 1) % 4096)) begin
                    errors++;
                    $display("FAIL %s_rd_addr c=%0d: got %0d expected %0d", name, c, rd_addr,
                             (base + c - 1) % 4096);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_stream();
        test_timed("stream", 16, 8, -1);
    endtask

    task automatic test_wrap();
        test_timed("wrap", 4094, 4, -1);
    endtask

    task automatic test_ignored_start();
        test_timed("ignored_start", 200, 10, 4);
    endtask

    task automatic test_lengths();
        @(negedge clk);
        start = 1'b1; base_addr = 12'd5; length = 13'd0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL len0 c=%0d: got busy=%b done=%b valid=%b expected 0 0 0", c, busy, done, m_valid);
            end
        end
        test_timed("len1", 7, 1, -1);
    endtask

    // Random backpressure against the reference byte queue
    task automatic test_backpressure(input int base, input int len, input int pct);
        logic [7:0] q[$];
        logic [7:0] pd, exp_d;
        logic       pv, pr, pl, fin;
        int         n, budget;
        n = (len > 4096) ? 4096 : len;
        for (int i = 0; i < n; i++) q.push_back(mem[(base + i) % 4096]);
        @(negedge clk);
        start = 1'b1; base_addr = 12'(base); length = 13'(len);
        m_ready = (int'($urandom_range(99)) < pct);
        pv = 1'b0; pr = 1'b0; pd = 8'h00; pl = 1'b0; fin = 1'b0;
        budget = n * 40 + 100;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (pv && !pr) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
                    errors++;
                    $display("FAIL bp_stall_hold: got v=%b data=%h last=%b expected v=1 data=%h last=%b",
                             m_valid, m_data, m_last, pd, pl);
                end
            end
            m_ready = (int'($urandom_range(99)) < pct);
            if (m_valid && m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_beat: got data=%h expected no transfer", m_data);
                end else begin
                    exp_d = q.pop_front();
                    if (m_data !== exp_d || m_last !== (q.size() == 0)) begin
                        errors++;
                        $display("FAIL bp_beat: got data=%h last=%b expected data=%h last=%b",
                                 m_data, m_last, exp_d, (q.size() == 0));
                    end
                end
            end
            if (done) begin
                fin = 1'b1;
                checks++;
                if (busy !== 1'b0 || q.size() != 0) begin
                    errors++;
                    $display("FAIL bp_done: got busy=%b remaining=%0d expected busy=0 remaining=0", busy, q.size());
                end
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL bp_timeout: got no done expected done, remaining=%0d", q.size());
        end
        m_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_after_done: got v=%b done=%b busy=%b expected 0 0 0", m_valid, done, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
            test_backpressure(int'($urandom_range(4095)), int'($urandom_range(600, 1)),
                              int'($urandom_range(100, 20)));
        end
        preload();
    endtask

    task automatic test_abort();
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 12'd0; length = 13'd20; m_ready = 1'b1;
        for (int c = 0; c < 50 && n < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && m_ready) n++;
        end
        abort = 1'b1;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL abort_reach: got %0d transfers expected 5", n);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_flush: got v=%b busy=%b last=%b done=%b expected 0 0 0 0",
                     m_valid, busy, m_last, done);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: got done=%b v=%b expected 0 0", done, m_valid);
            end
        end
        test_backpressure(0, 2, 100);
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        start = 1'b1; base_addr = 12'd100; length = 13'd50; m_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
            m_data !== 8'h00 || rd_addr !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid: got busy=%b done=%b valid=%b last=%b data=%h addr=%h expected all 0",
                     busy, done, m_valid, m_last, m_data, rd_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        base_addr = '0; length = '0;
        preload();
        test_reset();
        test_stream();
        test_wrap();
        test_backpressure(0, 300, 50);
        test_lengths();
        test_backpressure(10, 5000, 100);
        test_abort();
        test_rst_mid();
        test_ignored_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
